// File: rtl/anomaly_alarm_filter_pkg.sv
// Shared types and defaults for the anomaly alarm filter slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package anomaly_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        HOLD  = 2'd2
    } alarm_state_t;

    localparam int ALARM_WINDOW_DEF    = 16;
    localparam int ALARM_THRESHOLD_DEF = 4;
    localparam int ALARM_HOLD_DEF      = 1024;
    localparam int ALARM_CNT_W_DEF     = 16;

    // Bits needed to hold any value 0..max_val; never less than one bit.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/anomaly_alarm_filter_if.sv
// Detector/host-facing signal bundle of the anomaly alarm filter.
// Latency: none (wiring only).
// Backpressure: none; strobe and ack are single-cycle pulses, outputs are levels/pulses.
interface anomaly_alarm_filter_if #(
    parameter int WINDOW = anomaly_pkg::ALARM_WINDOW_DEF,
    parameter int CNT_W  = anomaly_pkg::ALARM_CNT_W_DEF
);
    import anomaly_pkg::*;

    localparam int CW = count_width(WINDOW);

    logic             sample_strobe;
    logic             anomaly_detected;
    logic             alarm_ack;
    logic             alarm;
    logic             alarm_rise;
    logic             holdoff;
    logic [CW-1:0]    window_count;
    logic [CNT_W-1:0] alarm_count;

    // Detector and host side.
    modport master (
        output sample_strobe, anomaly_detected, alarm_ack,
        input  alarm, alarm_rise, holdoff, window_count, alarm_count
    );

    // Filter side.
    modport slave (
        input  sample_strobe, anomaly_detected, alarm_ack,
        output alarm, alarm_rise, holdoff, window_count, alarm_count
    );

endinterface

// File: rtl/anomaly_alarm_filter_window.sv
// Sliding window of the last WINDOW decisions with a running count of ones.
// Latency: count registered one cycle after shift_en/clear; count_next is combinational.
// Backpressure: none; accepts a shift every cycle, clear has priority over shift.
module anomaly_window_counter #(
    parameter int WINDOW = 16,
    parameter int CW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          shift_en,
    input  logic          bit_in,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);

    logic [WINDOW-1:0] bits_q;

    // Running count: add the incoming bit, drop the one falling off the old end.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (shift_en) begin
            count_next = count + CW'(bit_in) - CW'(bits_q[WINDOW-1]);
        end
    end

    // Window history and registered count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bits_q <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (clear) begin
                bits_q <= '0;
            end else if (shift_en) begin
                bits_q <= {bits_q[WINDOW-2:0], bit_in};
            end
        end
    end

endmodule

// File: rtl/anomaly_alarm_filter.sv
// k-of-N anomaly alarm with host acknowledge, post-ack hold-off and saturating event count.
// Latency: alarm/alarm_rise one cycle after the triggering strobe; all outputs registered.
// Backpressure: none; strobes accepted every cycle in IDLE/ALARM, dropped during HOLD.
module anomaly_alarm_filter
    import anomaly_pkg::*;
#(
    parameter int WINDOW      = ALARM_WINDOW_DEF,
    parameter int THRESHOLD   = ALARM_THRESHOLD_DEF,
    parameter int HOLD_CYCLES = ALARM_HOLD_DEF,
    parameter int CNT_W       = ALARM_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    anomaly_alarm_filter_if.slave alarm_bus
);

    localparam int CW = count_width(WINDOW);
    localparam int TW = count_width(HOLD_CYCLES);

    if (WINDOW < 2 || WINDOW > 64 || THRESHOLD < 1 || THRESHOLD > WINDOW) begin : g_param_check
        $error("anomaly_alarm_filter: WINDOW must be 2..64 and THRESHOLD 1..WINDOW");
    end

    alarm_state_t     state;
    logic [TW-1:0]    hold_timer;
    logic             alarm_q;
    logic             rise_q;
    logic             holdoff_q;
    logic [CNT_W-1:0] alarm_cnt_q;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             ack_in_alarm;
    logic             shift_en;

    // An ack in ALARM wins over a same-cycle strobe; HOLD never samples.
    assign ack_in_alarm = (state == ALARM) && alarm_bus.alarm_ack;
    assign shift_en     = alarm_bus.sample_strobe &&
                          ((state == IDLE) || ((state == ALARM) && !alarm_bus.alarm_ack));

    anomaly_window_counter #(
        .WINDOW (WINDOW),
        .CW     (CW)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .bit_in     (alarm_bus.anomaly_detected),
        .clear      (ack_in_alarm),
        .count      (count),
        .count_next (count_next)
    );

    // Alarm FSM with hold-off timer and saturating alarm event counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            alarm_q     <= 1'b0;
            rise_q      <= 1'b0;
            holdoff_q   <= 1'b0;
            hold_timer  <= '0;
            alarm_cnt_q <= '0;
        end else begin
            rise_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (shift_en && (count_next >= CW'(THRESHOLD))) begin
                        state   <= ALARM;
                        alarm_q <= 1'b1;
                        rise_q  <= 1'b1;
                        if (alarm_cnt_q != {CNT_W{1'b1}}) begin
                            alarm_cnt_q <= alarm_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ALARM: begin
                    if (alarm_bus.alarm_ack) begin
                        state      <= HOLD;
                        alarm_q    <= 1'b0;
                        holdoff_q  <= 1'b1;
                        hold_timer <= TW'(HOLD_CYCLES);
                    end
                end
                HOLD: begin
                    if (hold_timer == '0) begin
                        state     <= IDLE;
                        holdoff_q <= 1'b0;
                    end else begin
                        hold_timer <= hold_timer - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign alarm_bus.alarm        = alarm_q;
    assign alarm_bus.alarm_rise   = rise_q;
    assign alarm_bus.holdoff      = holdoff_q;
    assign alarm_bus.window_count = count;
    assign alarm_bus.alarm_count  = alarm_cnt_q;

endmodule

// File: tb/tb_anomaly_alarm_filter.sv
// Bench for anomaly_alarm_filter: two configurations driven with shared directed stimulus.
// Latency: outputs compared at every falling edge against a sample-history model.
// Backpressure: not applicable; stimulus is pulse driven.
module tb_anomaly_alarm_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic stb   = 1'b0;
    logic anom  = 1'b0;
    logic ack   = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    anomaly_alarm_filter_if #(.WINDOW(16), .CNT_W(2))  bus0 ();
    anomaly_alarm_filter_if #(.WINDOW(4),  .CNT_W(16)) bus1 ();

    assign bus0.sample_strobe    = stb;
    assign bus0.anomaly_detected = anom;
    assign bus0.alarm_ack        = ack;
    assign bus1.sample_strobe    = stb;
    assign bus1.anomaly_detected = anom;
    assign bus1.alarm_ack        = ack;

    anomaly_alarm_filter #(.WINDOW(16), .THRESHOLD(4), .HOLD_CYCLES(8), .CNT_W(2)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .alarm_bus (bus0.slave)
    );

    anomaly_alarm_filter #(.WINDOW(4), .THRESHOLD(3), .HOLD_CYCLES(1024), .CNT_W(16)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .alarm_bus (bus1.slave)
    );

    // Model: full history of accepted samples, newest in bit 0.
    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_ALARM = 2'd1;
    localparam logic [1:0] M_HOLD  = 2'd2;

    typedef struct packed {
        logic [1:0]  mode;
        logic        alarm;
        logic        rise;
        logic        holdoff;
        logic [63:0] hist;
        int          left;
        int          acount;
    } mdl_t;

    mdl_t m0 = '0;
    mdl_t m1 = '0;

    function automatic int ones(logic [63:0] h, int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(h[i]);
        return s;
    endfunction

    function automatic mdl_t step(mdl_t m, logic r, logic s, logic a, logic k,
                                  int n, int thr, int hold, int cmax);
        mdl_t x;
        x = m;
        x.rise = 1'b0;
        if (!r) begin
            x = '0;
        end else if (m.mode == M_HOLD) begin
            if (m.left == 0) begin
                x.mode    = M_IDLE;
                x.holdoff = 1'b0;
            end else begin
                x.left = m.left - 1;
            end
        end else if (m.mode == M_ALARM && k) begin
            x.mode    = M_HOLD;
            x.alarm   = 1'b0;
            x.holdoff = 1'b1;
            x.hist    = '0;
            x.left    = hold;
        end else if (s) begin
            x.hist = {m.hist[62:0], a};
            if (m.mode == M_IDLE && ones(x.hist, n) >= thr) begin
                x.mode   = M_ALARM;
                x.alarm  = 1'b1;
                x.rise   = 1'b1;
                x.acount = (m.acount < cmax) ? m.acount + 1 : cmax;
            end
        end
        return x;
    endfunction

    always @(posedge clk) begin
        m0 = step(m0, reset, stb, anom, ack, 16, 4, 8, 3);
        m1 = step(m1, reset, stb, anom, ack, 4, 3, 1024, 65535);
    end

    task automatic cmp(string nm, logic a, logic r, logic h,
                       logic [31:0] wc, logic [31:0] ac, mdl_t m, int n);
        logic [31:0] ewc;
        logic [31:0] eac;
        ewc = 32'(ones(m.hist, n));
        eac = 32'(m.acount);
        checks++;
        if (a !== m.alarm || r !== m.rise || h !== m.holdoff || wc !== ewc || ac !== eac) begin
            errors++;
            $display("FAIL %s model t=%0t: got alarm=%0b rise=%0b hold=%0b wc=%0d cnt=%0d, expected alarm=%0b rise=%0b hold=%0b wc=%0d cnt=%0d",
                     nm, $time, a, r, h, wc, ac, m.alarm, m.rise, m.holdoff, ewc, eac);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("dut0", bus0.alarm, bus0.alarm_rise, bus0.holdoff,
                32'(bus0.window_count), 32'(bus0.alarm_count), m0, 16);
            cmp("dut1", bus1.alarm, bus1.alarm_rise, bus1.holdoff,
                32'(bus1.window_count), 32'(bus1.alarm_count), m1, 4);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs from a falling edge; return at the next falling edge.
    task automatic cyc(logic r, logic s, logic a, logic k);
        reset = r;
        stb   = s;
        anom  = a;
        ack   = k;
        @(negedge clk);
        reset = 1'b1;
        stb   = 1'b0;
        anom  = 1'b0;
        ack   = 1'b0;
    endtask

    // Count dut0 cycles with holdoff high, optionally strobing and acking throughout.
    task automatic wait_hold(output int n, input logic strobe_on);
        n = 0;
        while (bus0.holdoff && n < 40) begin
            n++;
            cyc(1'b1, strobe_on, 1'b1, n[0]);
            if (bus0.holdoff) chk("hold_window_zero", 32'(bus0.window_count), 0);
        end
    endtask

    task automatic ones4();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic chk_zero0(string nm);
        chk({nm, "_alarm"},   32'(bus0.alarm), 0);
        chk({nm, "_rise"},    32'(bus0.alarm_rise), 0);
        chk({nm, "_holdoff"}, 32'(bus0.holdoff), 0);
        chk({nm, "_wc"},      32'(bus0.window_count), 0);
        chk({nm, "_cnt"},     32'(bus0.alarm_count), 0);
    endtask

    bit pat_ev[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int exp_ev[7]  = '{1, 2, 2, 2, 1, 1, 2};
    bit pat_th[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int exp_sat[5] = '{1, 2, 3, 3, 3};

    initial begin
        int n;
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk_zero0("reset");
        chk("reset_wc1", 32'(bus1.window_count), 0);

        // Eviction on the 4-wide window, threshold 3.
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1, pat_ev[i], 1'b0);
            chk("evict_wc", 32'(bus1.window_count), 32'(exp_ev[i]));
            chk("evict_no_alarm", 32'(bus1.alarm), 0);
        end

        // Threshold crossing on the 16-wide window, threshold 4.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, pat_th[i], 1'b0);
            if (i == 4) chk("thr_before", 32'(bus0.alarm), 0);
        end
        chk("thr_alarm", 32'(bus0.alarm), 1);
        chk("thr_rise", 32'(bus0.alarm_rise), 1);
        chk("thr_wc", 32'(bus0.window_count), 4);
        chk("thr_cnt", 32'(bus0.alarm_count), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("thr_rise_drop", 32'(bus0.alarm_rise), 0);
        chk("thr_alarm_held", 32'(bus0.alarm), 1);

        // Ack together with an anomalous strobe, then hold-off.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("ack_alarm", 32'(bus0.alarm), 0);
        chk("ack_holdoff", 32'(bus0.holdoff), 1);
        chk("ack_wc", 32'(bus0.window_count), 0);
        wait_hold(n, 1'b1);
        chk("holdoff_cycles", 32'(n), 9);
        chk("reentry_strobe_ignored", 32'(bus0.window_count), 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("first_strobe_after_hold", 32'(bus0.window_count), 1);

        // Spurious ack in IDLE.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("idle_ack_wc", 32'(bus0.window_count), 1);
        chk("idle_ack_alarm", 32'(bus0.alarm), 0);
        chk("idle_ack_hold", 32'(bus0.holdoff), 0);
        chk("idle_ack_cnt", 32'(bus0.alarm_count), 1);

        // Saturation of the 2-bit alarm counter.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            ones4();
            chk("sat_alarm", 32'(bus0.alarm), 1);
            chk("sat_cnt", 32'(bus0.alarm_count), 32'(exp_sat[k]));
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            wait_hold(n, 1'b0);
            chk("sat_holdoff_cycles", 32'(n), 9);
        end

        // Reset during ALARM and during HOLD.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        ones4();
        chk("mid_alarm", 32'(bus0.alarm), 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk_zero0("rst_in_alarm");
        ones4();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_hold", 32'(bus0.holdoff), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk_zero0("rst_in_hold");
        ones4();
        chk("post_rst_alarm", 32'(bus0.alarm), 1);
        chk("post_rst_cnt", 32'(bus0.alarm_count), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
